foc_startup_sequencer: RTL

Sequences motor start-up for the FOC drive on the 40 MHz domain. Runs open-loop rotor alignment, then an accelerating open-loop SVPWM sweep using the svpwm inputs v_amp/v_rho/v_theta. It then hands over to the closed-loop foc_controller by asserting a select and supplying id_aim/iq_aim. In closed loop, iq_aim is trimmed from the two board keys.

---
 rtl/foc_pkg.sv | 41 ++++
 rtl/key_step_sync.sv | 59 +++++
 rtl/foc_startup_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/foc_pkg.sv
// Shared definitions for the FOC start-up sequencer: state codes, widths,
// the registered drive bundle and the saturating iq step helper.
package foc_pkg;

  localparam int THETA_W = 12;
  localparam int AMP_W   = 9;
  localparam int IQ_W    = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_RAMP  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [THETA_W-1:0] THETA_MAX = '1;

  typedef struct packed {
    logic [2:0]                state;
    logic [AMP_W-1:0]          amp;
    logic [THETA_W-1:0]        rho;
    logic [THETA_W-1:0]        theta;
    logic                      sel;
    logic signed [IQ_W-1:0]    iq;
  } drive_t;

  // Adds a -1/0/+1 step to a and clamps the result to [-lim, +lim].
  function automatic logic signed [IQ_W-1:0] sat_add(
    input logic signed [IQ_W-1:0] a,
    input logic signed [1:0]      d,
    input logic signed [IQ_W-1:0] lim
  );
    logic signed [IQ_W:0] sum;
    logic signed [IQ_W:0] lim_x;
    sum   = $signed({a[IQ_W-1], a}) + $signed({{(IQ_W-1){d[1]}}, d});
    lim_x = $signed({lim[IQ_W-1], lim});
    if (sum > lim_x)       return lim;
    else if (sum < -lim_x) return -lim;
    else                   return $signed(sum[IQ_W-1:0]);
  endfunction

endpackage

// File: rtl/key_step_sync.sv
// Board key front end: 2-flop synchronisers, KEY_TICK pacing counter and
// the +1/-1/0 iq step decode. Keys are active low.
module key_step_sync
  import foc_pkg::*;
#(
  parameter logic [31:0] KEY_TICK = 32'd200000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              key_up,
  input  logic              key_dn,
  output logic signed [1:0] step
);

  logic [1:0]  up_sync;
  logic [1:0]  dn_sync;
  logic [31:0] tick_cnt;
  logic        tick;
  logic        up_on;
  logic        dn_on;

  assign up_on = ~up_sync[1];
  assign dn_on = ~dn_sync[1];
  assign tick  = en && (tick_cnt == KEY_TICK - 32'd1);

  // Synchronisers reset to the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_sync <= 2'b11;
      dn_sync <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments keep the two flops a true shift chain.
      up_sync <= {up_sync[0], key_up};
      dn_sync <= {dn_sync[0], key_dn};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
      step     <= '0;
    end else begin
      if (!en || tick) tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + 32'd1;

      if (tick) begin
        case ({up_on, dn_on})
          2'b10:   step <= 2'sd1;
          2'b01:   step <= -2'sd1;
          default: step <= 2'sd0;
        endcase
      end else begin
        step <= 2'sd0;
      end
    end
  end

endmodule

// File: rtl/foc_startup_sequencer.sv
// FOC start-up sequencer: IDLE -> ALIGN -> RAMP (open-loop sweep) -> RUN.
// Optional macro FOC_STARTUP_SOFTALIGN_EN ramps v_amp up gently in ALIGN.
module foc_startup_sequencer
  import foc_pkg::*;
#(
  parameter logic [AMP_W-1:0]       ALIGN_AMP         = 9'd100,
  parameter logic [31:0]            ALIGN_CYCLES      = 32'd40_000_000,
  parameter logic [15:0]            RAMP_PERIOD_START = 16'd1525,
  parameter logic [15:0]            RAMP_PERIOD_END   = 16'd200,
  parameter logic [15:0]            RAMP_PERIOD_DEC   = 16'd25,
  parameter logic signed [IQ_W-1:0] IQ_INIT           = 16'sd0,
  parameter logic signed [IQ_W-1:0] IQ_MAX            = 16'sd800,
  parameter logic [31:0]            KEY_TICK          = 32'd200000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic                      i_fault,
  input  logic                      i_key_up,
  input  logic                      i_key_dn,
  output logic [AMP_W-1:0]          o_v_amp,
  output logic [THETA_W-1:0]        o_v_rho,
  output logic [THETA_W-1:0]        o_v_theta,
  output logic                      o_sel_closed,
  output logic signed [IQ_W-1:0]    o_id_aim,
  output logic signed [IQ_W-1:0]    o_iq_aim,
  output logic [2:0]                o_state,
  output logic                      o_busy
);

`ifdef FOC_STARTUP_SOFTALIGN_EN
  localparam logic [AMP_W-1:0] AMP_ENTRY = '0;
  logic [15:0] soft_cnt, soft_nxt;
`else
  localparam logic [AMP_W-1:0] AMP_ENTRY = ALIGN_AMP;
`endif

  // Handover happens when the post-decrement period would reach the end value.
  localparam logic [16:0] PERIOD_HANDOVER = {1'b0, RAMP_PERIOD_END} + {1'b0, RAMP_PERIOD_DEC};

  drive_t            cur, nxt;
  logic              busy;
  logic [31:0]       dwell_cnt, dwell_nxt;
  logic [15:0]       period, period_nxt;
  logic [15:0]       step_cnt, step_nxt;
  logic              dwell_en;
  logic signed [1:0] key_step;

  key_step_sync #(.KEY_TICK(KEY_TICK)) u_keys (
    .clk    (clk),
    .rstn   (rstn),
    .en     (cur.state == ST_RUN),
    .key_up (i_key_up),
    .key_dn (i_key_dn),
    .step   (key_step)
  );

`ifdef FOC_STARTUP_SOFTALIGN_EN
  assign dwell_en = (cur.amp == ALIGN_AMP);
`else
  assign dwell_en = 1'b1;
`endif

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    nxt        = cur;
    dwell_nxt  = dwell_cnt;
    period_nxt = period;
    step_nxt   = step_cnt;
`ifdef FOC_STARTUP_SOFTALIGN_EN
    soft_nxt   = soft_cnt;
`endif
    if (i_fault || i_stop) begin
      // Stop and fault both drop every drive output; fault only changes the code.
      nxt        = '0;
      nxt.state  = i_fault ? ST_FAULT : ST_IDLE;
      dwell_nxt  = '0;
      period_nxt = '0;
      step_nxt   = '0;
`ifdef FOC_STARTUP_SOFTALIGN_EN
      soft_nxt   = '0;
`endif
    end else begin
      case (cur.state)
        ST_IDLE: begin
          if (i_start) begin
            nxt.state = ST_ALIGN;
            nxt.amp   = AMP_ENTRY;
            nxt.rho   = THETA_MAX;
            nxt.theta = '0;
            dwell_nxt = '0;
`ifdef FOC_STARTUP_SOFTALIGN_EN
            soft_nxt  = '0;
`endif
          end
        end
        ST_ALIGN: begin
`ifdef FOC_STARTUP_SOFTALIGN_EN
          if (!dwell_en) begin
            soft_nxt = soft_cnt + 16'd1;
            if (soft_cnt == 16'hFFFF) nxt.amp = cur.amp + 9'd1;
          end
`endif
          if (dwell_en) begin
            if (dwell_cnt == ALIGN_CYCLES - 32'd1) begin
              nxt.state  = ST_RAMP;
              period_nxt = RAMP_PERIOD_START;
              step_nxt   = '0;
            end else begin
              dwell_nxt = dwell_cnt + 32'd1;
            end
          end
        end
        ST_RAMP: begin
          if (step_cnt == period - 16'd1) begin
            step_nxt  = '0;
            nxt.theta = cur.theta + 12'd1;
            if (cur.theta == THETA_MAX) begin
              if ({1'b0, period} <= PERIOD_HANDOVER) begin
                nxt       = '0;
                nxt.state = ST_RUN;
                nxt.sel   = 1'b1;
                nxt.iq    = IQ_INIT;
              end else begin
                period_nxt = period - RAMP_PERIOD_DEC;
              end
            end
          end else begin
            step_nxt = step_cnt + 16'd1;
          end
        end
        ST_RUN:   nxt.iq = sat_add(cur.iq, key_step, IQ_MAX);
        ST_FAULT: ;
        default:  nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur       <= '0;
      busy      <= 1'b0;
      dwell_cnt <= '0;
      period    <= '0;
      step_cnt  <= '0;
`ifdef FOC_STARTUP_SOFTALIGN_EN
      soft_cnt  <= '0;
`endif
    end else begin
      cur       <= nxt;
      busy      <= (nxt.state == ST_ALIGN) || (nxt.state == ST_RAMP) || (nxt.state == ST_RUN);
      dwell_cnt <= dwell_nxt;
      period    <= period_nxt;
      step_cnt  <= step_nxt;
`ifdef FOC_STARTUP_SOFTALIGN_EN
      soft_cnt  <= soft_nxt;
`endif
    end
  end

  assign o_state      = cur.state;
  assign o_v_amp      = cur.amp;
  assign o_v_rho      = cur.rho;
  assign o_v_theta    = cur.theta;
  assign o_sel_closed = cur.sel;
  assign o_iq_aim     = cur.iq;
  assign o_id_aim     = '0;
  assign o_busy       = busy;

endmodule
